// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT front end (frame collector and FFT_step1..3):
//   FFT_SAMPLES / FFT_WIDTH : default frame length and sample width
//   ADDR_W                  : slot index width for the default frame length
//   fill_state_e            : number of full banks in the ping-pong collector
//   bitrev()                : reverses the low 'bits' bits of an index
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_SAMPLES = 8;
  localparam int FFT_WIDTH   = 3;
  localparam int ADDR_W      = $clog2(FFT_SAMPLES);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fill_state_e;

  // Bits at or above 'bits' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[bits - 1 - i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// -----------------------------------------------------------------------------
// fft_frame_bank
// One SAMPLES x WIDTH register bank. All slots are readable in parallel;
// a single slot is written per cycle. Cleared to zero by reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_we       : write enable
//   i_addr     : slot to write
//   i_data     : sample to write
//   o_data     : all slots, element i is slot i
// -----------------------------------------------------------------------------
module fft_frame_bank #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_we,
  input  logic [$clog2(SAMPLES)-1:0] i_addr,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data [SAMPLES]
);

  logic [WIDTH-1:0] r_mem [SAMPLES];

  // NOTE: this is a register array, not a RAM, so it can be reset; the
  // zero-on-reset contents are what sampleInputs shows before the first frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLES; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/fft_frame_collector.sv
// -----------------------------------------------------------------------------
// fft_frame_collector
// Serial-to-parallel collector feeding FFT_step1. Samples arrive over a
// valid/ready handshake and are assembled into SAMPLES-long frames in two
// ping-pong banks, so one frame can fill while the other is held downstream.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/ready  : sample handshake, in_sample is the data
//   frame_valid/rdy : frame handshake, sampleInputs is the frame (slot i)
//   frame_cnt       : frames consumed, wraps 255 -> 0
// Build option: define FFT_BITREV_LOAD_EN to write sample k into slot
// bitrev(k), leaving sampleInputs in decimation-in-time input order.
// -----------------------------------------------------------------------------
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int SAMPLES = FFT_SAMPLES,
  parameter int WIDTH   = FFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sample,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] sampleInputs [SAMPLES],
  output logic [7:0]       frame_cnt
);

  localparam int IDX_W = $clog2(SAMPLES);

  fill_state_e      r_state, w_state_nxt;
  logic             r_wr_bank, w_wr_bank_nxt;
  logic             r_rd_bank, w_rd_bank_nxt;
  logic [IDX_W-1:0] r_wr_idx, w_wr_idx_nxt;
  logic [7:0]       r_frame_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_consume;
  logic [IDX_W-1:0] w_wr_addr;
  logic [WIDTH-1:0] w_bank0_data [SAMPLES];
  logic [WIDTH-1:0] w_bank1_data [SAMPLES];

  // Handshake outputs come from registered state only.
  assign in_ready    = (r_state != TWO);
  assign frame_valid = (r_state != EMPTY);
  assign frame_cnt   = r_frame_cnt;

  assign w_accept  = in_valid & in_ready;
  assign w_last    = w_accept && (r_wr_idx == IDX_W'(SAMPLES - 1));
  assign w_consume = frame_valid & frame_ready;

`ifdef FFT_BITREV_LOAD_EN
  assign w_wr_addr = IDX_W'(bitrev(32'(r_wr_idx), IDX_W));
`else
  assign w_wr_addr = r_wr_idx;
`endif

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_accept & ~r_wr_bank),
    .i_addr (w_wr_addr),
    .i_data (in_sample),
    .o_data (w_bank0_data)
  );

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_accept & r_wr_bank),
    .i_addr (w_wr_addr),
    .i_data (in_sample),
    .o_data (w_bank1_data)
  );

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      sampleInputs[i] = r_rd_bank ? w_bank1_data[i] : w_bank0_data[i];
    end
  end

  // Next-state logic. The fill bank always flips on a last-sample accept;
  // in ONE that makes it point at the held bank, which becomes the fill bank
  // again once the held frame is consumed out of TWO.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_wr_bank_nxt = r_wr_bank ^ w_last;
    w_wr_idx_nxt  = r_wr_idx;

    if (w_accept) w_wr_idx_nxt = w_last ? '0 : r_wr_idx + 1'b1;

    unique case (r_state)
      EMPTY: begin
        if (w_last) begin
          w_state_nxt   = ONE;
          w_rd_bank_nxt = r_wr_bank;
        end
      end
      ONE: begin
        if (w_last && w_consume) begin
          w_rd_bank_nxt = r_wr_bank;
        end else if (w_last) begin
          w_state_nxt = TWO;
        end else if (w_consume) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_consume) begin
          w_state_nxt   = ONE;
          w_rd_bank_nxt = ~r_rd_bank;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_wr_idx  <= w_wr_idx_nxt;
      if (w_consume) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

endmodule

// File: doc/fft_frame_collector.md
# fft_frame_collector

Serial-to-parallel frame collector that sits directly upstream of FFT_step1. Accepts one WIDTH-bit sample per cycle over a valid/ready handshake and assembles SAMPLES consecutive samples into a frame. Completed frames are presented as the `sampleInputs` array that FFT_step1 consumes. Ping-pong double buffering allows a new frame to fill while the previous one is held for the FFT.

## Interface
Parameters:
- SAMPLES, 8, samples per frame; power of two, ≥ 2
- WIDTH, 3, bits per sample

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  in_sample carries a sample
- in_ready  out  1  collector can accept a sample this cycle
- in_sample  in  WIDTH  sample data
- frame_valid  out  1  sampleInputs holds a complete frame
- frame_ready  in  1  downstream consumes the frame this cycle
- sampleInputs  out  [WIDTH-1:0] x [SAMPLES-1:0] (unpacked)  presented frame; element i is slot i
- frame_cnt  out  8  completed frames consumed, wraps 255→0

## Operation
- Two banks, each SAMPLES x WIDTH. wr_bank selects the bank being filled; rd_bank selects the bank driving sampleInputs.
- wr_idx counts 0..SAMPLES-1 within the fill bank.
- Sample accept: in_valid & in_ready. Sample k of a frame is written to slot k, or to slot bitrev(k) under the macro.
- When in_ready=0, in_valid is ignored. The source holds its data.
- Frame consume: frame_valid & frame_ready. On consume, frame_cnt increments.
- State machine (count of full banks):
  - EMPTY: frame_valid=0, in_ready=1. Last-sample accept → ONE; rd_bank ← filled bank; wr_bank toggles.
  - ONE: frame_valid=1, in_ready=1.
    - Consume only → EMPTY.
    - Last-sample accept only → TWO.
    - Both in the same cycle → stay in ONE; rd_bank ← newly filled bank; wr_bank toggles.
  - TWO: frame_valid=1, in_ready=0. Consume → ONE; rd_bank toggles; fill resumes in the freed bank with wr_idx=0.
- Non-last accepts increment wr_idx and leave the state unchanged. wr_idx wraps to 0 on the last accept.
- sampleInputs stays stable while frame_valid=1 and no consume has occurred.
- sampleInputs contents while frame_valid=0 are don't-care, but deterministic: they reflect the rd_bank registers.
- Reset: state EMPTY; wr_idx=0; wr_bank=rd_bank=0; all bank registers 0; frame_cnt=0. Consequently in_ready=1, frame_valid=0, and sampleInputs all 0.
- Reset mid-frame discards any partial or pending frame.

## Timing
- in_ready and frame_valid are decoded from registered state only. There is no combinational path from in_valid or frame_ready.
- Latency: the accept of the last sample at edge t makes frame_valid=1 immediately after t, with the frame visible on sampleInputs.
- Consume at edge t in TWO: in_ready=1 after t.
- Sustained throughput is 1 sample/cycle, provided each frame is consumed within SAMPLES cycles of becoming valid.
- frame_cnt updates on the consume edge.

## Configuration
- FFT_BITREV_LOAD_EN defined: sample k is written to slot bitrev(k) over $clog2(SAMPLES) bits. sampleInputs is then already in bit-reversed order for a decimation-in-time butterfly.
- FFT_BITREV_LOAD_EN undefined: natural order, slot k = sample k.
- Handshake, state machine and timing are identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - default SAMPLES and WIDTH
  - ADDR_W = $clog2(SAMPLES)
  - state enum {EMPTY, ONE, TWO}
  - function bitrev(idx, ADDR_W)
  - These are shared with FFT_step1..3.
- Sub-module fft_frame_bank: one SAMPLES x WIDTH register bank with write enable, write address and a clear on reset. The collector instantiates it twice.

## Test plan
- Reset then stream 0..7 back-to-back, frame_ready=1:
  - frame_valid rises the cycle after sample 7 is accepted.
  - Without the macro, sampleInputs={0..7}.
  - With FFT_BITREV_LOAD_EN, slots 0..7 = {0,4,2,6,1,5,3,7}.
  - frame_cnt=1.
- Stream three frames with frame_ready=0:
  - After frame 2 completes, in_ready=0 and sampleInputs still shows frame 1.
  - Raise frame_ready for 1 cycle: frame 2 is shown and in_ready=1 the next cycle.
- Same-cycle last-sample accept and consume in ONE:
  - State stays ONE and frame_valid stays 1.
  - sampleInputs switches to the new frame with no bubble.
- Assert in_valid toggling randomly while in_ready=0: no sample is written and wr_idx is unchanged.
- Assert rst_n low after 5 samples, then stream 8 new samples:
  - The first frame contains only the new samples.
  - frame_cnt restarts at 0.
- Consume 256 frames: frame_cnt wraps to 0.
